// File: rtl/ts_pkt_scheduler.sv
// rtl/ts_pkt_scheduler.sv - packet-aligned round-robin scheduler for the 4-channel TS byte mux
//
// Purpose:
//   Grants one whole TS packet (PKT_LEN bytes) at a time to one of four
//   channel buffers and never switches channel mid-packet. Drives the mux
//   select, the per-channel read strobes and the output FIFO write strobe.
//   A grant needs an enabled channel holding a full packet and FIFO room
//   for a full packet.
//
// Optional feature macro: SYNC_CHECK_EN
//   When defined, the first byte written for each packet is compared with
//   SYNC_BYTE. On a mismatch, sync_err pulses and none of that packet's
//   bytes are written, although all of its bytes are still read.
//   When undefined, sync_err is tied low and every byte is written.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   ch_pkt_avail   per-channel "complete packet buffered" flags
//   ch_enable      per-channel QoS enables
//   fifo_space_ok  downstream FIFO can take a full packet
//   sel_data       byte currently presented by the mux to the FIFO
//   mux_ctrl       mux channel select (0..3)
//   ch_rd_en       one-hot read strobe to the channel buffers
//   fifo_wr_en     write strobe to the output FIFO
//   pkt_done       one-cycle pulse with the last byte write of a packet
//   sync_err       one-cycle pulse on a first-byte sync mismatch
//   busy           high while a packet is in transfer

module ts_pkt_scheduler #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(8'h47)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ch_pkt_avail,
    input  logic [3:0]            ch_enable,
    input  logic                  fifo_space_ok,
    input  logic [DATA_WIDTH-1:0] sel_data,
    output logic [1:0]            mux_ctrl,
    output logic [3:0]            ch_rd_en,
    output logic                  fifo_wr_en,
    output logic                  pkt_done,
    output logic                  sync_err,
    output logic                  busy
);

    localparam int CW = $clog2(PKT_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]    last_ptr_q, last_ptr_d;
    logic [1:0]    mux_d;
    logic [3:0]    rd_d;
    logic          busy_d;
    logic          done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting channel after the last grant.
    // ------------------------------------------------------------------
    logic [3:0] req;
    logic       grant_found;
    logic [1:0] grant_idx;
    logic       grant;

    assign req = ch_pkt_avail & ch_enable;

    always_comb begin
        logic [1:0] cand;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        // Offsets 1..4 wrap naturally in 2 bits; offset 4 revisits the
        // last-granted channel so a lone requester is regranted.
        for (int i = 1; i <= 4; i++) begin
            cand = last_ptr_q + 2'(i);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = grant_found && fifo_space_ok;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is computed here one
    // cycle ahead and registered below.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        mux_d      = mux_ctrl;
        rd_d       = 4'b0000;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d    = XFER;
                    last_ptr_d = grant_idx;
                    mux_d      = grant_idx;
                    rd_d       = 4'b0001 << grant_idx;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
            end

            XFER: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Last read is happening now; its byte is written
                    // during FLUSH, which is also when pkt_done shows.
                    state_d = FLUSH;
                    done_d  = 1'b1;
                end else begin
                    rd_d  = 4'b0001 << mux_ctrl;
                    cnt_d = cnt_q + CW'(1);
                end
            end

            FLUSH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr_q <= 2'd3;
            mux_ctrl   <= 2'd0;
            ch_rd_en   <= 4'b0000;
            busy       <= 1'b0;
            pkt_done   <= 1'b0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
        end else begin
            last_ptr_q <= last_ptr_d;
            mux_ctrl   <= mux_d;
            ch_rd_en   <= rd_d;
            busy       <= busy_d;
            pkt_done   <= done_d;
            cnt_q      <= cnt_d;
            // Channel buffers have one cycle of read latency, so a byte
            // read in cycle t is on sel_data and written in cycle t+1.
            wr_q       <= |ch_rd_en;
        end
    end

`ifdef SYNC_CHECK_EN
    // ------------------------------------------------------------------
    // First-byte sync check
    // ------------------------------------------------------------------
    logic first_wr_q;
    logic bad_pkt_q;
    logic sync_err_q;
    logic sync_mismatch;

    // first_wr_q marks the cycle in which byte 0 of the packet is on
    // sel_data (one cycle after the first read).
    assign sync_mismatch = first_wr_q && (sel_data != SYNC_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_wr_q <= 1'b0;
            bad_pkt_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            first_wr_q <= (state_q == XFER) && (cnt_q == '0);
            sync_err_q <= sync_mismatch;
            if (state_q == IDLE && grant) begin
                bad_pkt_q <= 1'b0;
            end else if (sync_mismatch) begin
                bad_pkt_q <= 1'b1;
            end
        end
    end

    // The first byte has to be blocked in the same cycle it is compared,
    // so the mismatch gates the registered strobe directly; bad_pkt_q
    // blocks the rest of the packet. Reads continue untouched so the
    // channel buffer stays packet-aligned.
    assign fifo_wr_en = wr_q && !bad_pkt_q && !sync_mismatch;
    assign sync_err   = sync_err_q;
`else
    logic unused_sync_inputs;

    assign unused_sync_inputs = ^(sel_data ^ SYNC_BYTE);
    assign fifo_wr_en         = wr_q;
    assign sync_err           = 1'b0;
`endif

endmodule

// File: tb/tb_ts_pkt_scheduler.sv
// tb/tb_ts_pkt_scheduler.sv - self-checking bench for ts_pkt_scheduler

module tb_ts_pkt_scheduler;

    localparam int          PKT_LEN   = 188;
    localparam logic [7:0]  SYNC_BYTE = 8'h47;
`ifdef SYNC_CHECK_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ch_pkt_avail = 4'b0000;
    logic [3:0] ch_enable = 4'b0000;
    logic       fifo_space_ok = 1'b0;
    logic [7:0] sel_data = 8'h00;
    logic [1:0] mux_ctrl;
    logic [3:0] ch_rd_en;
    logic       fifo_wr_en;
    logic       pkt_done;
    logic       sync_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_chan_q[$];

    ts_pkt_scheduler #(
        .DATA_WIDTH (8),
        .PKT_LEN    (PKT_LEN),
        .SYNC_BYTE  (SYNC_BYTE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_pkt_avail  (ch_pkt_avail),
        .ch_enable     (ch_enable),
        .fifo_space_ok (fifo_space_ok),
        .sel_data      (sel_data),
        .mux_ctrl      (mux_ctrl),
        .ch_rd_en      (ch_rd_en),
        .fifo_wr_en    (fifo_wr_en),
        .pkt_done      (pkt_done),
        .sync_err      (sync_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mux_ctrl"}, 32'(mux_ctrl), 0);
        check({tag, "_ch_rd_en"}, 32'(ch_rd_en), 0);
        check({tag, "_fifo_wr_en"}, 32'(fifo_wr_en), 0);
        check({tag, "_pkt_done"}, 32'(pkt_done), 0);
        check({tag, "_sync_err"}, 32'(sync_err), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Observes one packet from grant to end of FLUSH, sampling on negedges.
    // The bench plays the channel buffer: the byte read in cycle k is put on
    // sel_data for cycle k+1, byte 0 being first_byte.
    task automatic run_pkt(input logic [7:0] first_byte, input int drop_at,
                           input logic [3:0] drop_mask, input int rst_at);
        int         wait_n = 0;
        int         k = 0;
        int         rd_n = 0;
        int         wr_n = 0;
        int         done_n = 0;
        int         sync_n = 0;
        int         bad = 0;
        bit         aborted = 1'b0;
        bit         bad_pkt;
        logic [1:0] chan;
        logic [1:0] exp_chan;
        logic [3:0] oh;
        logic [3:0] exp_rd;
        logic       exp_wr;

        while (!busy && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("grant_seen", 32'(busy), 1);
        if (!busy) return;

        chan     = mux_ctrl;
        oh       = 4'b0001 << chan;
        exp_chan = (exp_chan_q.size() > 0) ? exp_chan_q.pop_front() : 2'd0;
        check("grant_chan", 32'(chan), 32'(exp_chan));
        bad_pkt  = SYNC_ON && (first_byte != SYNC_BYTE);

        while (busy && k < 400 && !aborted) begin
            k++;
            exp_rd = (k <= PKT_LEN) ? oh : 4'b0000;
            exp_wr = !bad_pkt && (k >= 2) && (k <= PKT_LEN + 1);
            if (ch_rd_en !== exp_rd) bad++;
            if (fifo_wr_en !== exp_wr) bad++;
            if (pkt_done !== (k == PKT_LEN + 1)) bad++;
            if (sync_err !== (bad_pkt && k == 3)) bad++;
            if (mux_ctrl !== chan) bad++;
            if (ch_rd_en === oh) rd_n++;
            if (fifo_wr_en === 1'b1) wr_n++;
            if (pkt_done === 1'b1) done_n++;
            if (sync_err === 1'b1) sync_n++;

            sel_data = (k == 1) ? first_byte : 8'(k);
            if (k == drop_at) begin
                ch_pkt_avail = ch_pkt_avail & ~drop_mask;
                ch_enable    = ch_enable & ~drop_mask;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_outputs_zero("mid_reset");
                aborted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        if (!aborted) begin
            check("busy_cycles", 32'(k), PKT_LEN + 1);
            check("rd_count", 32'(rd_n), PKT_LEN);
            check("wr_count", 32'(wr_n), bad_pkt ? 0 : PKT_LEN);
            check("done_count", 32'(done_n), 1);
            check("sync_count", 32'(sync_n), bad_pkt ? 1 : 0);
            check("cycle_timing", 32'(bad), 0);
        end
    endtask

    initial begin
        int hold_bad;

        // Reset state
        #1;
        check_outputs_zero("por");
        repeat (2) @(negedge clk);
        check_outputs_zero("por_hold");

        // Single requester on channel 0
        ch_pkt_avail  = 4'b0001;
        ch_enable     = 4'b1111;
        fifo_space_ok = 1'b1;
        rst           = 1'b0;
        exp_chan_q.push_back(2'd0);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 0);

        // All four requesting: round robin from channel 0 after reset
        ch_pkt_avail = 4'b1111;
        apply_reset();
        for (int i = 0; i < 8; i++) exp_chan_q.push_back(2'(i));
        for (int i = 0; i < 8; i++) run_pkt(SYNC_BYTE, 0, 4'b0000, 0);

        // Masked requests and FIFO back-pressure
        ch_pkt_avail  = 4'b1010;
        ch_enable     = 4'b0010;
        fifo_space_ok = 1'b0;
        hold_bad      = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ch_rd_en !== 4'b0000 || fifo_wr_en !== 1'b0) hold_bad++;
        end
        check("space_hold_idle", 32'(hold_bad), 0);
        fifo_space_ok = 1'b1;
        exp_chan_q.push_back(2'd1);
        exp_chan_q.push_back(2'd1);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 0);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 0);

        // Inputs dropped mid-packet: channel 2 completes, channel 3 skipped
        ch_pkt_avail = 4'b1101;
        ch_enable    = 4'b1111;
        exp_chan_q.push_back(2'd2);
        exp_chan_q.push_back(2'd0);
        run_pkt(SYNC_BYTE, 50, 4'b1100, 0);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 0);

        // First-byte sync: bad then good
        ch_pkt_avail = 4'b0001;
        exp_chan_q.push_back(2'd0);
        exp_chan_q.push_back(2'd0);
        run_pkt(8'h00, 0, 4'b0000, 0);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 0);

        // Reset mid-packet on channel 1, then channel 0 must win again
        ch_pkt_avail = 4'b0010;
        exp_chan_q.push_back(2'd1);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 100);
        repeat (2) @(negedge clk);
        ch_pkt_avail = 4'b1111;
        rst          = 1'b0;
        exp_chan_q.push_back(2'd0);
        run_pkt(SYNC_BYTE, 0, 4'b0000, 0);

        ch_pkt_avail = 4'b0000;
        repeat (4) @(negedge clk);
        check("final_idle", 32'(busy), 0);
        check("scoreboard_empty", 32'(exp_chan_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
